mm2s_frame_reader: RTL and testbench

Read-side DataMover front end for the convolution core. It turns one frame-load request (base address, byte count) into a single 72-bit AXI DataMover MM2S command. It then collects the returned byte stream into a small FIFO and presents it to the convolution datapath as a valid/ready pixel stream. It also reports completion and length mismatches, which feed the core's IRQ event.

---
 rtl/conv_pkg.sv | 43 ++++
 rtl/sync_fifo.sv | 65 ++++++
 rtl/mm2s_frame_reader.sv | 171 +++++++++++++++++
 tb/tb_mm2s_frame_reader.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the convolution core read path: DataMover command
// field layout, command builder and the frame-reader state enum.
`timescale 1ns/1ps
package conv_pkg;

    localparam int unsigned DM_CMD_W    = 72;
    localparam int unsigned DM_BTT_LSB  = 0;
    localparam int unsigned DM_BTT_W    = 23;
    localparam int unsigned DM_TYPE_BIT = 23;
    localparam int unsigned DM_EOF_BIT  = 30;
    localparam int unsigned DM_ADDR_LSB = 32;
    localparam int unsigned DM_ADDR_W   = 32;
    localparam int unsigned DM_TAG_LSB  = 64;
    localparam int unsigned DM_TAG_W    = 4;

    localparam logic TYPE_INCR = 1'b1;
    localparam logic EOF_SET   = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_DATA  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } rd_state_e;

    // Builds an INCR, end-of-frame MM2S command; all other fields stay zero.
    function automatic logic [DM_CMD_W-1:0] dm_cmd(
        input logic [DM_ADDR_W-1:0] addr,
        input logic [DM_BTT_W-1:0]  len,
        input logic [DM_TAG_W-1:0]  tag
    );
        logic [DM_CMD_W-1:0] c;
        c = '0;
        c[DM_BTT_LSB +: DM_BTT_W]   = len;
        c[DM_TYPE_BIT]              = TYPE_INCR;
        c[DM_EOF_BIT]               = EOF_SET;
        c[DM_ADDR_LSB +: DM_ADDR_W] = addr;
        c[DM_TAG_LSB +: DM_TAG_W]   = tag;
        return c;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty flags and extra-bit pointers.
// A write while full is accepted when a read happens in the same cycle.
`timescale 1ns/1ps
module sync_fifo #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_wr_en,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic                     i_rd_en,
    output logic [WIDTH-1:0]         o_rd_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wp;
    logic [PW-1:0]    r_rp;
    logic             r_full;
    logic             r_empty;

    logic             w_wr;
    logic             w_rd;
    logic [PW-1:0]    w_wp_n;
    logic [PW-1:0]    w_rp_n;

    assign w_wr   = i_wr_en & (~r_full | i_rd_en);
    assign w_rd   = i_rd_en & ~r_empty;
    assign w_wp_n = r_wp + PW'(w_wr);
    assign w_rp_n = r_rp + PW'(w_rd);

    // Pointer and flag update; flags are precomputed from next pointers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            r_wp    <= w_wp_n;
            r_rp    <= w_rp_n;
            r_full  <= (w_wp_n - w_rp_n) == PW'(DEPTH);
            r_empty <= w_wp_n == w_rp_n;
        end
    end

    // Storage array; flushing is done through the pointers only.
    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem[r_wp[AW-1:0]] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[r_rp[AW-1:0]];
    assign o_full    = r_full;
    assign o_empty   = r_empty;
    assign o_count   = r_wp - r_rp;

endmodule

// File: rtl/mm2s_frame_reader.sv
// Frame-load front end: issues one DataMover MM2S command per start, buffers
// the returned bytes and presents them as a pixel stream.
// Optional build macro: MM2S_RD_LEN_CHECK_EN (byte counting, length error,
// discarding of beats beyond btt).
`timescale 1ns/1ps
module mm2s_frame_reader
    import conv_pkg::*;
#(
    parameter int unsigned STREAM_DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH        = 16,
    parameter logic [3:0]  CMD_TAG           = 4'h0
) (
    input  logic                         sys_clk,
    input  logic                         sys_rst,
    input  logic                         start,
    input  logic [31:0]                  base_addr,
    input  logic [22:0]                  btt,
    output logic                         busy,
    output logic                         done,
    output logic                         len_err,
    output logic                         m_axis_mm2s_cmd_tvalid,
    input  logic                         m_axis_mm2s_cmd_tready,
    output logic [DM_CMD_W-1:0]          m_axis_mm2s_cmd_tdata,
    input  logic                         s_axis_mm2s_tvalid,
    input  logic                         s_axis_mm2s_tlast,
    input  logic                         s_axis_mm2s_tkeep,
    input  logic [STREAM_DATA_WIDTH-1:0] s_axis_mm2s_tdata,
    output logic                         s_axis_mm2s_tready,
    output logic                         pix_valid,
    input  logic                         pix_ready,
    output logic [STREAM_DATA_WIDTH-1:0] pix_data,
    output logic                         pix_last
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned ENT_W = STREAM_DATA_WIDTH + 1;

    rd_state_e             r_state;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_cmd_tvalid;
    logic [DM_CMD_W-1:0]   r_cmd_tdata;

    logic                  w_full;
    logic                  w_empty;
    logic [PTR_W-1:0]      w_count;
    logic [ENT_W-1:0]      w_fifo_dout;
    logic                  w_beat;
    logic                  w_wr;
    logic                  w_rd;
    logic                  w_last_flag;
    logic                  w_drain_done;

    assign s_axis_mm2s_tready = (r_state == ST_DATA) & ~w_full;
    assign w_beat             = s_axis_mm2s_tvalid & s_axis_mm2s_tready;
    assign w_rd               = pix_ready & ~w_empty;
    assign w_drain_done       = (w_count == '0) | ((w_count == PTR_W'(1)) & w_rd);

`ifdef MM2S_RD_LEN_CHECK_EN
    logic [DM_BTT_W-1:0]   r_btt;
    logic [DM_BTT_W-1:0]   r_cnt;
    logic                  r_len_err;
    logic [DM_BTT_W-1:0]   w_cnt_n;

    // Only kept beats inside the requested length are stored and counted.
    assign w_wr        = w_beat & s_axis_mm2s_tkeep & (r_cnt < r_btt);
    assign w_cnt_n     = r_cnt + DM_BTT_W'(w_wr);
    assign w_last_flag = (w_cnt_n == r_btt) | s_axis_mm2s_tlast;
    assign len_err     = r_len_err;
`else
    assign w_wr        = w_beat & s_axis_mm2s_tkeep;
    assign w_last_flag = s_axis_mm2s_tlast;
    assign len_err     = 1'b0;
`endif

    // Frame sequencing: command issue, data collection, drain and completion.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_cmd_tvalid <= 1'b0;
            r_cmd_tdata  <= '0;
`ifdef MM2S_RD_LEN_CHECK_EN
            r_btt        <= '0;
            r_cnt        <= '0;
            r_len_err    <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_busy <= 1'b1;
`ifdef MM2S_RD_LEN_CHECK_EN
                        r_btt     <= btt;
                        r_cnt     <= '0;
                        r_len_err <= 1'b0;
`endif
                        if (btt != '0) begin
                            r_cmd_tdata  <= dm_cmd(base_addr, btt, CMD_TAG);
                            r_cmd_tvalid <= 1'b1;
                            r_state      <= ST_CMD;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_CMD: begin
                    if (m_axis_mm2s_cmd_tready) begin
                        r_cmd_tvalid <= 1'b0;
                        r_state      <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_beat) begin
`ifdef MM2S_RD_LEN_CHECK_EN
                        r_cnt <= w_cnt_n;
                        if (s_axis_mm2s_tlast && (w_cnt_n != r_btt)) begin
                            r_len_err <= 1'b1;
                        end
`endif
                        if (s_axis_mm2s_tlast) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_drain_done) begin
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy       <= 1'b0;
                    r_cmd_tvalid <= 1'b0;
                    r_state      <= ST_IDLE;
                end
            endcase
        end
    end

    sync_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk     (sys_clk),
        .i_rst     (sys_rst),
        .i_wr_en   (w_wr),
        .i_wr_data ({w_last_flag, s_axis_mm2s_tdata}),
        .i_rd_en   (pix_ready),
        .o_rd_data (w_fifo_dout),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_count   (w_count)
    );

    assign busy                   = r_busy;
    assign done                   = r_done;
    assign m_axis_mm2s_cmd_tvalid = r_cmd_tvalid;
    assign m_axis_mm2s_cmd_tdata  = r_cmd_tdata;
    assign pix_valid              = ~w_empty;
    assign pix_data               = w_empty ? '0 : w_fifo_dout[STREAM_DATA_WIDTH-1:0];
    assign pix_last               = ~w_empty & w_fifo_dout[STREAM_DATA_WIDTH];

endmodule

// File: tb/tb_mm2s_frame_reader.sv
// Self-checking bench for mm2s_frame_reader: table of frame vectors plus
// hand-written reset sequences.
`timescale 1ns/1ps
module tb_mm2s_frame_reader;

`ifdef MM2S_RD_LEN_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        start;
    logic [31:0] base_addr;
    logic [22:0] btt;
    logic        busy, done, len_err;
    logic        cmd_tvalid, cmd_tready;
    logic [71:0] cmd_tdata;
    logic        s_tvalid, s_tlast, s_tkeep, s_tready;
    logic [7:0]  s_tdata;
    logic        pix_valid, pix_ready, pix_last;
    logic [7:0]  pix_data;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 sys_clk = ~sys_clk;

    mm2s_frame_reader #(
        .STREAM_DATA_WIDTH (8),
        .FIFO_DEPTH        (16),
        .CMD_TAG           (4'h0)
    ) dut (
        .sys_clk                (sys_clk),
        .sys_rst                (sys_rst),
        .start                  (start),
        .base_addr              (base_addr),
        .btt                    (btt),
        .busy                   (busy),
        .done                   (done),
        .len_err                (len_err),
        .m_axis_mm2s_cmd_tvalid (cmd_tvalid),
        .m_axis_mm2s_cmd_tready (cmd_tready),
        .m_axis_mm2s_cmd_tdata  (cmd_tdata),
        .s_axis_mm2s_tvalid     (s_tvalid),
        .s_axis_mm2s_tlast      (s_tlast),
        .s_axis_mm2s_tkeep      (s_tkeep),
        .s_axis_mm2s_tdata      (s_tdata),
        .s_axis_mm2s_tready     (s_tready),
        .pix_valid              (pix_valid),
        .pix_ready              (pix_ready),
        .pix_data               (pix_data),
        .pix_last               (pix_last)
    );

    typedef struct {
        logic [31:0] base;
        logic [22:0] len;
        int          nbeats;
        logic [31:0] keep;
        int          cmd_delay;
        int          pix_hold;
        int          restart_at;
        bit          pre_reset;
        bit          exp_cmd;
        logic [71:0] exp_tdata;
        int          exp_npix;
        int          exp_last;
        logic        exp_len_err;
        int          exp_acc_hold;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] dat(input int vi, input int i);
        return 8'(vi * 40 + i * 5 + 1);
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},       72'(busy),       72'd0);
        check({tag, "_done"},       72'(done),       72'd0);
        check({tag, "_len_err"},    72'(len_err),    72'd0);
        check({tag, "_cmd_tvalid"}, 72'(cmd_tvalid), 72'd0);
        check({tag, "_cmd_tdata"},  cmd_tdata,       72'd0);
        check({tag, "_s_tready"},   72'(s_tready),   72'd0);
        check({tag, "_pix_valid"},  72'(pix_valid),  72'd0);
        check({tag, "_pix_data"},   72'(pix_data),   72'd0);
        check({tag, "_pix_last"},   72'(pix_last),   72'd0);
    endtask

    // Start a 16-byte frame, accept 5 beats with the sink stalled, then reset.
    task automatic mid_reset();
        int beats;
        bit cmd_ok;
        beats  = 0;
        cmd_ok = 1'b0;
        @(posedge sys_clk); #1;
        start = 1'b1; base_addr = 32'h7000_0000; btt = 23'd16;
        @(posedge sys_clk); #1;
        start = 1'b0; pix_ready = 1'b0; cmd_tready = 1'b1;
        for (int c = 0; c < 60 && beats < 5; c++) begin
            s_tvalid = cmd_ok; s_tkeep = 1'b1; s_tlast = 1'b0; s_tdata = 8'(8'hA0 + beats);
            @(negedge sys_clk);
            if (cmd_tvalid && cmd_tready) cmd_ok = 1'b1;
            if (s_tvalid && s_tready) beats++;
            @(posedge sys_clk); #1;
        end
        s_tvalid = 1'b0; cmd_tready = 1'b0;
        check("rst_beats_before", 72'(beats), 72'd5);
        check("rst_pix_valid_before", 72'(pix_valid), 72'd1);
        check("rst_busy_before", 72'(busy), 72'd1);
        #2 sys_rst = 1'b1;
        #1 check_all_zero("midrst");
        @(posedge sys_clk); #1 sys_rst = 1'b0;
        @(negedge sys_clk);
        check_all_zero("postrst");
    endtask

    task automatic run_frame(input int vi);
        vec_t v;
        logic [7:0] expq [$];
        int cnt, src, npix, last_idx, last_cnt, acc_hold, last_hs, done_cyc, exp_done;
        bit cmd_ok, seen_cmd;
        v = vecs[vi];
        cnt = 0;
        for (int i = 0; i < v.nbeats; i++) begin
            if (v.keep[i] && (!CHK || cnt < int'(v.len))) begin
                expq.push_back(dat(vi, i));
                cnt++;
            end
        end
        src = 0; npix = 0; last_idx = 0; last_cnt = 0; acc_hold = 0;
        last_hs = -1; done_cyc = -1; cmd_ok = 1'b0; seen_cmd = 1'b0;

        @(posedge sys_clk); #1;
        start = 1'b1; base_addr = v.base; btt = v.len;
        @(posedge sys_clk); #1;
        start = 1'b0; base_addr = '0; btt = '0;
        check($sformatf("v%0d_busy_at_start", vi), 72'(busy), 72'd1);
        check($sformatf("v%0d_len_err_cleared", vi), 72'(len_err), 72'd0);
        check($sformatf("v%0d_cmd_tvalid_at_start", vi), 72'(cmd_tvalid), 72'(v.exp_cmd));

        for (int c = 0; c < 300; c++) begin
            cmd_tready = (c >= v.cmd_delay);
            s_tvalid   = cmd_ok && (src < v.nbeats);
            s_tdata    = dat(vi, src);
            s_tkeep    = v.keep[src];
            s_tlast    = (src == v.nbeats - 1);
            pix_ready  = (c >= v.pix_hold);
            if (c == v.restart_at) begin
                start = 1'b1; base_addr = 32'hDEAD_BEEF; btt = 23'd99;
            end else begin
                start = 1'b0;
            end
            @(negedge sys_clk);
            if (cmd_tvalid) begin
                check($sformatf("v%0d_cmd_tdata", vi), cmd_tdata, v.exp_tdata);
                seen_cmd = 1'b1;
                if (cmd_tready) cmd_ok = 1'b1;
            end
            if (s_tvalid && s_tready) begin
                src++;
                if (c < v.pix_hold) acc_hold++;
            end
            if (pix_valid && pix_ready) begin
                if (npix < expq.size())
                    check($sformatf("v%0d_pix%0d", vi, npix), 72'(pix_data), 72'(expq[npix]));
                else
                    check($sformatf("v%0d_extra_pix", vi), 72'(npix), 72'(expq.size()));
                if (pix_last) begin
                    last_idx = npix + 1;
                    last_cnt++;
                end
                npix++;
                last_hs = c;
            end
            if (done) begin
                done_cyc = c;
                break;
            end
            @(posedge sys_clk); #1;
        end

        start = 1'b0; s_tvalid = 1'b0; cmd_tready = 1'b0; pix_ready = 1'b0;
        check($sformatf("v%0d_done_seen", vi), 72'(done_cyc >= 0), 72'd1);
        check($sformatf("v%0d_len_err_at_done", vi), 72'(len_err), 72'(v.exp_len_err));
        check($sformatf("v%0d_npix", vi), 72'(npix), 72'(v.exp_npix));
        check($sformatf("v%0d_last_idx", vi), 72'(last_idx), 72'(v.exp_last));
        check($sformatf("v%0d_last_cnt", vi), 72'(last_cnt), 72'((v.exp_npix > 0) ? 1 : 0));
        check($sformatf("v%0d_cmd_seen", vi), 72'(seen_cmd), 72'(v.exp_cmd));
        exp_done = (v.exp_npix > 0) ? last_hs + 1 : 0;
        check($sformatf("v%0d_done_cycle", vi), 72'(done_cyc), 72'(exp_done));
        if (v.pix_hold > 0)
            check($sformatf("v%0d_acc_while_stalled", vi), 72'(acc_hold), 72'(v.exp_acc_hold));
        @(negedge sys_clk);
        check($sformatf("v%0d_done_one_cycle", vi), 72'(done), 72'd0);
        check($sformatf("v%0d_busy_after", vi), 72'(busy), 72'd0);
        check($sformatf("v%0d_len_err_sticky", vi), 72'(len_err), 72'(v.exp_len_err));
    endtask

    initial begin
        vecs[0] = '{32'h1000_0000, 23'd16, 16, 32'hFFFF_FFFF, 3, 0, -1, 1'b0,
                    1'b1, 72'h00_1000_0000_4080_0010, 16, 16, 1'b0, 0};
        vecs[1] = '{32'h2000_0100, 23'd16, 12, 32'hFFFF_FFFF, 0, 0, -1, 1'b0,
                    1'b1, 72'h00_2000_0100_4080_0010, 12, 12, CHK, 0};
        vecs[2] = '{32'h0000_4000, 23'd8, 20, 32'hFFFF_FFFF, 1, 40, -1, 1'b0,
                    1'b1, 72'h00_0000_4000_4080_0008, CHK ? 8 : 20, CHK ? 8 : 20, 1'b0,
                    CHK ? 20 : 16};
        vecs[3] = '{32'h5000_0000, 23'd0, 0, 32'h0, 0, 0, -1, 1'b0,
                    1'b0, 72'h0, 0, 0, 1'b0, 0};
        vecs[4] = '{32'h3000_0000, 23'd4, 7, 32'h0000_0055, 2, 0, -1, 1'b0,
                    1'b1, 72'h00_3000_0000_4080_0004, 4, 4, 1'b0, 0};
        vecs[5] = '{32'h0000_0040, 23'd4, 4, 32'h0000_000F, 0, 0, 4, 1'b1,
                    1'b1, 72'h00_0000_0040_4080_0004, 4, 4, 1'b0, 0};

        sys_rst = 1'b1; start = 1'b0; base_addr = '0; btt = '0;
        cmd_tready = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tkeep = 1'b0;
        s_tdata = '0; pix_ready = 1'b0;
        @(negedge sys_clk);
        check_all_zero("reset");
        @(posedge sys_clk); #1 sys_rst = 1'b0;
        @(negedge sys_clk);

        for (int vi = 0; vi < 6; vi++) begin
            if (vecs[vi].pre_reset) mid_reset();
            run_frame(vi);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
